// File: rtl/fpg_pix_pkg.sv
// Shared pixel types and the unsigned 16-bit saturation helper used by the
// content-loss forward and backward blocks.
package fpg_pix_pkg;

    typedef logic [15:0]        pixel_t;
    typedef logic signed [16:0] diff_t;

    localparam pixel_t PIX_MAX = 16'hFFFF;

    // Per-lane contents of the first pipeline stage.
    typedef struct packed {
        diff_t       d;
        logic [31:0] sq;
        pixel_t      gen;
    } s1_lane_t;

    function automatic pixel_t sat_u16(input logic signed [18:0] v);
        if (v < 19'sd0)
            return '0;
        else if (v > 19'sd65535)
            return PIX_MAX;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/content_grad_update_if.sv
// Stream bundle for content_grad_update: input pixel pairs, updated pixel
// output and the per-frame loss report.
interface content_grad_update_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 48
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [LANES*16-1:0]  content_pixels;
    logic [LANES*16-1:0]  generated_pixels;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [LANES*16-1:0]  out_pixels;
    logic                 loss_valid;
    logic [ACC_W-1:0]     loss_out;

    modport master (
        output in_valid, in_last, content_pixels, generated_pixels, out_ready,
        input  in_ready, out_valid, out_last, out_pixels, loss_valid, loss_out
    );

    modport slave (
        input  in_valid, in_last, content_pixels, generated_pixels, out_ready,
        output in_ready, out_valid, out_last, out_pixels, loss_valid, loss_out
    );
endinterface

// File: rtl/grad_lane.sv
// Combinational per-lane math: diff and square from the live inputs, updated
// pixel from the stage-1 registered diff and generated pixel.
module grad_lane
    import fpg_pix_pkg::*;
#(
    parameter int unsigned LR_SHIFT = 3
) (
    input  pixel_t      gen,
    input  pixel_t      content,
    output diff_t       d,
    output logic [31:0] sq,
    input  diff_t       d_q,
    input  pixel_t      gen_q,
    output pixel_t      new_pix
);
    logic [15:0]        mag;
    logic signed [17:0] twice;
    logic signed [17:0] step;
    logic signed [18:0] upd;

    always_comb begin
        d     = $signed({1'b0, gen}) - $signed({1'b0, content});
        // |d| never exceeds 65535, so the square fits 32 bits unsigned.
        mag   = d[16] ? 16'(-d) : 16'(d);
        sq    = 32'(mag) * 32'(mag);
        twice = {d_q, 1'b0};
        step  = twice >>> LR_SHIFT;
        upd   = $signed({3'b000, gen_q}) - $signed({step[17], step});
        new_pix = sat_u16(upd);
    end
endmodule

// File: rtl/content_grad_update.sv
// Content-loss backward stage: two-stage pixel update pipeline with a global
// stall and a per-frame saturating squared-error accumulator.
module content_grad_update
    import fpg_pix_pkg::*;
#(
    parameter int unsigned LANES    = 4,
    parameter int unsigned LR_SHIFT = 3,
    parameter int unsigned ACC_W    = 48
) (
    input  logic               clk,
    input  logic               reset,
    content_grad_update_if.slave bus
);
    localparam int unsigned BS_W = 32 + $clog2(LANES);

    pixel_t      lane_gen [LANES];
    pixel_t      lane_con [LANES];
    diff_t       lane_d   [LANES];
    logic [31:0] lane_sq  [LANES];
    pixel_t      lane_new [LANES];

    s1_lane_t            s1_lane_q [LANES];
    s1_lane_t            s1_lane_d [LANES];
    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q,  s1_last_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_last_q,  s2_last_d;
    logic [LANES*16-1:0] s2_pix_q,   s2_pix_d;
    logic [ACC_W-1:0]    acc_q,      acc_d;
    logic [ACC_W-1:0]    loss_out_q, loss_out_d;
    logic                loss_valid_q, loss_valid_d;

    logic                advance;
    logic [BS_W-1:0]     beat_sum;
    logic [ACC_W:0]      acc_sum;
    logic [ACC_W-1:0]    acc_sat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_gen[i] = bus.generated_pixels[16*i +: 16];
        assign lane_con[i] = bus.content_pixels[16*i +: 16];

        grad_lane #(.LR_SHIFT(LR_SHIFT)) u_lane (
            .gen     (lane_gen[i]),
            .content (lane_con[i]),
            .d       (lane_d[i]),
            .sq      (lane_sq[i]),
            .d_q     (s1_lane_q[i].d),
            .gen_q   (s1_lane_q[i].gen),
            .new_pix (lane_new[i])
        );
    end

    always_comb begin
        advance  = !s2_valid_q || bus.out_ready;

        beat_sum = '0;
        for (int unsigned i = 0; i < LANES; i++)
            beat_sum = beat_sum + BS_W'(s1_lane_q[i].sq);
        acc_sum = {1'b0, acc_q} + (ACC_W+1)'(beat_sum);
        acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

        s1_lane_d    = s1_lane_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s2_valid_d   = s2_valid_q;
        s2_last_d    = s2_last_q;
        s2_pix_d     = s2_pix_q;
        acc_d        = acc_q;
        loss_out_d   = loss_out_q;
        loss_valid_d = 1'b0;

        if (advance) begin
            s1_valid_d = bus.in_valid;
            s1_last_d  = bus.in_valid && bus.in_last;
            if (bus.in_valid)
                for (int unsigned i = 0; i < LANES; i++)
                    s1_lane_d[i] = '{d: lane_d[i], sq: lane_sq[i], gen: lane_gen[i]};

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            // beat_sum is consumed by acc/loss_out on the S1->S2 edge itself,
            // so it needs no separate S2 copy.
            if (s1_valid_q) begin
                for (int unsigned i = 0; i < LANES; i++)
                    s2_pix_d[16*i +: 16] = lane_new[i];
                if (s1_last_q) begin
                    loss_out_d   = acc_sat;
                    loss_valid_d = 1'b1;
                    acc_d        = '0;
                end else begin
                    acc_d = acc_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++)
                s1_lane_q[i] <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_pix_q     <= '0;
            acc_q        <= '0;
            loss_out_q   <= '0;
            loss_valid_q <= 1'b0;
        end else begin
            s1_lane_q    <= s1_lane_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            s2_pix_q     <= s2_pix_d;
            acc_q        <= acc_d;
            loss_out_q   <= loss_out_d;
            loss_valid_q <= loss_valid_d;
        end
    end

    assign bus.in_ready   = advance;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_last   = s2_last_q;
    assign bus.out_pixels = s2_pix_q;
    assign bus.loss_valid = loss_valid_q;
    assign bus.loss_out   = loss_out_q;
endmodule

// File: tb/tb_content_grad_update.sv
// Directed bench for content_grad_update: two instances (LR_SHIFT 3 and 0)
// share stimulus; expectations are hand-computed or from an integer model.
module tb_content_grad_update;
    import fpg_pix_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    content_grad_update_if #(.LANES(4), .ACC_W(48)) if3 ();
    content_grad_update_if #(.LANES(4), .ACC_W(48)) if0 ();

    content_grad_update #(.LANES(4), .LR_SHIFT(3), .ACC_W(48)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave));
    content_grad_update #(.LANES(4), .LR_SHIFT(0), .ACC_W(48)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Integer reference: floor division by 2^sh, then clamp to 0..65535.
    function automatic logic [15:0] ref_pix(input int g, input int c, input int sh);
        int twice, step, n;
        twice = 2 * (g - c);
        if (twice >= 0) step = twice / (1 << sh);
        else            step = -((-twice + (1 << sh) - 1) / (1 << sh));
        n = g - step;
        if (n < 0)     n = 0;
        if (n > 65535) n = 65535;
        return 16'(n);
    endfunction

    function automatic int bp_gen(input int k, input int l);
        return 1000 + 5000 * k + 300 * l;
    endfunction
    function automatic int bp_con(input int k, input int l);
        return 20000 - 2000 * k + 50 * l;
    endfunction

    task automatic set_in(input logic v, input logic l, input logic [63:0] g, input logic [63:0] c);
        if3.in_valid = v; if3.in_last = l; if3.generated_pixels = g; if3.content_pixels = c;
        if0.in_valid = v; if0.in_last = l; if0.generated_pixels = g; if0.content_pixels = c;
    endtask

    task automatic set_ordy(input logic r);
        if3.out_ready = r;
        if0.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] held_pix, e, g, c;
        logic        held_v, ordy;
        int unsigned k, got, pulses;
        logic [47:0] loss_a, loss_b;

        reset = 1'b1;
        set_in(1'b0, 1'b0, '0, '0);
        set_ordy(1'b1);
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_out_valid",  if3.out_valid,  0);
        chk("rst_out_last",   if3.out_last,   0);
        chk("rst_out_pixels", if3.out_pixels, 0);
        chk("rst_loss_valid", if3.loss_valid, 0);
        chk("rst_loss_out",   if3.loss_out,   0);
        chk("rst_in_ready",   if3.in_ready,   1);

        // Single-beat frame, d=100 on every lane.
        set_in(1'b1, 1'b1, pack4(1000, 1000, 1000, 1000), pack4(900, 900, 900, 900));
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        chk("t1_latency",    if3.out_valid,  0);
        tick();
        chk("t1_out_valid",  if3.out_valid,  1);
        chk("t1_pix_sh3",    if3.out_pixels, pack4(975, 975, 975, 975));
        chk("t1_pix_sh0",    if0.out_pixels, pack4(800, 800, 800, 800));
        chk("t1_out_last",   if3.out_last,   1);
        chk("t1_loss_valid", if3.loss_valid, 1);
        chk("t1_loss_out",   if3.loss_out,   40000);
        tick();
        chk("t1_pulse_end",  if3.loss_valid, 0);
        chk("t1_loss_hold",  if3.loss_out,   40000);
        chk("t1_drained",    if3.out_valid,  0);

        // Clamp and floor boundaries, beat_sum wider than 32 bits.
        set_in(1'b1, 1'b1, pack4(10, 60000, 100, 500), pack4(60000, 0, 103, 500));
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        tick();
        chk("clamp_sh0",  if0.out_pixels, pack4(65535, 0, 106, 500));
        chk("clamp_sh3",  if3.out_pixels, pack4(15008, 45000, 101, 500));
        chk("wide_loss",  if3.loss_out,   64'd7198800109);
        chk("wide_loss0", if0.loss_out,   64'd7198800109);
        tick();

        // Backpressure: out_ready pattern 1,0,0,1 over an 8-beat frame.
        k = 0; got = 0; held_v = 1'b0; held_pix = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            set_ordy(ordy);
            if (k < 8) begin
                for (int l = 0; l < 4; l++) begin
                    g[16*l +: 16] = 16'(bp_gen(int'(k), l));
                    c[16*l +: 16] = 16'(bp_con(int'(k), l));
                end
                set_in(1'b1, k == 7, g, c);
            end else begin
                set_in(1'b0, 1'b0, '0, '0);
            end
            #1;
            chk("bp_in_ready", if3.in_ready, !(if3.out_valid && !ordy));
            if (held_v)
                chk("bp_stable", if3.out_pixels, held_pix);
            if (if3.out_valid && ordy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("bp_pix",  if3.out_pixels, e);
                chk("bp_last", if3.out_last,   got == 7);
                got++;
            end
            held_v   = if3.out_valid && !ordy;
            held_pix = if3.out_pixels;
            if (k < 8 && if3.in_ready) begin
                for (int l = 0; l < 4; l++)
                    e[16*l +: 16] = ref_pix(bp_gen(int'(k), l), bp_con(int'(k), l), 3);
                exp_q.push_back(e);
                k++;
            end
            tick();
        end
        chk("bp_count", got, 8);
        set_ordy(1'b1);
        set_in(1'b0, 1'b0, '0, '0);
        tick(); tick();

        // Two back-to-back 3-beat frames: 3*4*100^2 and 3*4*30^2.
        pulses = 0; loss_a = '0; loss_b = '0;
        for (int i = 0; i < 15; i++) begin
            if (i < 3)      set_in(1'b1, i == 2, pack4(200, 200, 200, 200), pack4(100, 100, 100, 100));
            else if (i < 6) set_in(1'b1, i == 5, pack4(50, 50, 50, 50), pack4(80, 80, 80, 80));
            else            set_in(1'b0, 1'b0, '0, '0);
            tick();
            if (if3.loss_valid) begin
                if (pulses == 0) loss_a = if3.loss_out;
                else             loss_b = if3.loss_out;
                pulses++;
            end
        end
        chk("ff_pulses", pulses, 2);
        chk("ff_loss_a", loss_a, 120000);
        chk("ff_loss_b", loss_b, 10800);

        // Reset after two beats of a four-beat frame.
        set_in(1'b1, 1'b0, pack4(300, 300, 300, 300), '0);
        tick(); tick();
        set_in(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_out_valid",  if3.out_valid,  0);
        chk("rm_out_last",   if3.out_last,   0);
        chk("rm_out_pixels", if3.out_pixels, 0);
        chk("rm_loss_valid", if3.loss_valid, 0);
        chk("rm_loss_out",   if3.loss_out,   0);
        set_in(1'b1, 1'b1, pack4(7, 7, 7, 7), pack4(4, 4, 4, 4));
        pulses = 0; loss_a = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            set_in(1'b0, 1'b0, '0, '0);
            if (if3.loss_valid) begin
                loss_a = if3.loss_out;
                pulses++;
            end
        end
        chk("rm_pulses", pulses, 1);
        chk("rm_loss",   loss_a, 36);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
